// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the synchronous program ROM and queues tagged words for decode.
// Define FETCH_SKID_EN for the two-entry skid buffer (full rate); otherwise a single output register.
module instr_fetch #(
    parameter int          ADDR_WIDTH = 13,
    parameter int          DATA_WIDTH = 16,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_ad,
    output logic                  rom_ce,
    output logic                  rom_oce,
    output logic                  rom_reset,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_addr
);

`ifdef FETCH_SKID_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] head_instr_q, head_instr_d;
    logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
`ifdef FETCH_SKID_EN
    logic [DATA_WIDTH-1:0] tail_instr_q, tail_instr_d;
    logic [ADDR_WIDTH-1:0] tail_pc_q, tail_pc_d;
`endif

    logic                  jump;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occupancy;
    logic [ADDR_WIDTH-1:0] issue_addr;

    // A redirect is ignored while reset is asserted.
    assign jump       = jump_valid & ~reset;
    assign pop        = instr_valid & instr_ready;
    assign push       = inflight_q & ~jump;
    assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = jump | (~reset & (occupancy < 3'(DEPTH)));
    assign issue_addr = jump ? jump_addr : pc_q;

    assign rom_ce      = issue;
    assign rom_ad      = issue_addr;
    assign rom_oce     = 1'b1;
    assign rom_reset   = reset;
    assign instr_valid = (count_q != 2'd0);
    assign instr       = head_instr_q;
    assign instr_pc    = head_pc_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (issue) begin
            pc_d          = issue_addr + ADDR_WIDTH'(1);
            inflight_pc_d = issue_addr;
        end
    end

`ifdef FETCH_SKID_EN
    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        if (jump) begin
            count_d = 2'd0;
        end else begin
            unique case ({pop, push})
                2'b10: begin
                    count_d = count_q - 2'd1;
                    if (count_q == 2'd2) begin
                        head_instr_d = tail_instr_q;
                        head_pc_d    = tail_pc_q;
                    end
                end
                2'b01: begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd0) begin
                        head_instr_d = rom_dout;
                        head_pc_d    = inflight_pc_q;
                    end else begin
                        tail_instr_d = rom_dout;
                        tail_pc_d    = inflight_pc_q;
                    end
                end
                2'b11: begin
                    // Occupancy unchanged: the returning word lands in whichever slot frees up.
                    if (count_q == 2'd1) begin
                        head_instr_d = rom_dout;
                        head_pc_d    = inflight_pc_q;
                    end else begin
                        head_instr_d = tail_instr_q;
                        head_pc_d    = tail_pc_q;
                        tail_instr_d = rom_dout;
                        tail_pc_d    = inflight_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        if (jump) begin
            count_d = 2'd0;
        end else if (push) begin
            count_d      = 2'd1;
            head_instr_d = rom_dout;
            head_pc_d    = inflight_pc_q;
        end else if (pop) begin
            count_d = 2'd0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RST_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            head_instr_q  <= '0;
            head_pc_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            head_instr_q  <= head_instr_d;
            head_pc_q     <= head_pc_d;
        end
    end

`ifdef FETCH_SKID_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tail_instr_q <= '0;
            tail_pc_q    <= '0;
        end else begin
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a one-cycle-latency ROM model returning ad ^ 16'hA5A5.
// Cycle expectations follow FETCH_SKID_EN (DEPTH 2) or its absence (DEPTH 1).
module tb_instr_fetch;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam logic [DW-1:0] XORV = 16'hA5A5;
`ifdef FETCH_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic C3_VALID = (DEPTH == 2);

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rom_ad;
    logic          rom_ce;
    logic          rom_oce;
    logic          rom_reset;
    logic [DW-1:0] rom_dout = '0;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          jump_valid;
    logic [AW-1:0] jump_addr;

    int            checks = 0;
    int            errors = 0;
    int            accepts = 0;
    logic [AW-1:0] exp_pc = '0;

    instr_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .rom_ad     (rom_ad),
        .rom_ce     (rom_ce),
        .rom_oce    (rom_oce),
        .rom_reset  (rom_reset),
        .rom_dout   (rom_dout),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_ce) rom_dout <= {3'b000, rom_ad} ^ XORV;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every accepted word must be the next sequential address with its ROM data.
    task automatic mon_accept();
        if (instr_valid && instr_ready) begin
            check("acc_pc", 32'(instr_pc), 32'(exp_pc));
            check("acc_instr", 32'(instr), 32'({3'b000, exp_pc} ^ XORV));
            exp_pc = exp_pc + 1'b1;
            accepts++;
        end
    endtask

    task automatic next_cycle();
        mon_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            next_cycle();
        end
    endtask

    task automatic startup_checks(input string pfx);
        @(negedge clk);
        check({pfx, "_c0_ce"}, 32'(rom_ce), 32'd1);
        check({pfx, "_c0_ad"}, 32'(rom_ad), 32'd0);
        check({pfx, "_c0_valid"}, 32'(instr_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check({pfx, "_c1_valid"}, 32'(instr_valid), 32'd0);
        check({pfx, "_c1_ce"}, 32'(rom_ce), 32'(C3_VALID));
        next_cycle();
        @(negedge clk);
        check({pfx, "_c2_valid"}, 32'(instr_valid), 32'd1);
        check({pfx, "_c2_pc"}, 32'(instr_pc), 32'd0);
        next_cycle();
        @(negedge clk);
        check({pfx, "_c3_valid"}, 32'(instr_valid), 32'(C3_VALID));
        next_cycle();
    endtask

    task automatic do_jump(input string pfx, input logic [AW-1:0] target);
        jump_valid = 1'b1;
        jump_addr  = target;
        @(negedge clk);
        check({pfx, "_ce"}, 32'(rom_ce), 32'd1);
        check({pfx, "_ad"}, 32'(rom_ad), 32'(target));
        next_cycle();
        jump_valid = 1'b0;
        exp_pc     = target;
        @(negedge clk);
        check({pfx, "_j1_valid"}, 32'(instr_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check({pfx, "_j2_valid"}, 32'(instr_valid), 32'd1);
        check({pfx, "_j2_pc"}, 32'(instr_pc), 32'(target));
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset       = 1'b1;
        instr_ready = 1'b1;
        jump_valid  = 1'b0;
        jump_addr   = '0;

        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
        check("rst_ce", 32'(rom_ce), 32'd0);
        check("rst_ad", 32'(rom_ad), 32'd0);
        check("rst_oce", 32'(rom_oce), 32'd1);
        check("rst_romrst", 32'(rom_reset), 32'd1);
        @(posedge clk);
        #1;

        reset  = 1'b0;
        exp_pc = '0;
        startup_checks("boot");

        accepts = 0;
        run(20);
        check("throughput", 32'(accepts), 32'(10 * DEPTH));

        // Decode stall: head frozen at the next expected word, ROM idle once full.
        instr_ready = 1'b0;
        @(negedge clk);
        next_cycle();
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_ce", 32'(rom_ce), 32'd0);
            check("stall_pc", 32'(instr_pc), 32'(exp_pc));
            check("stall_instr", 32'(instr), 32'({3'b000, exp_pc} ^ XORV));
            next_cycle();
        end
        instr_ready = 1'b1;
        accepts = 0;
        run(12);
        check("resume_count", 32'(accepts), 32'(6 * DEPTH));

        n = 0;
        while (!instr_valid && n < 4) begin
            @(negedge clk);
            next_cycle();
            n++;
        end
        check("wait_valid", 32'(instr_valid), 32'd1);
        do_jump("jmp100", 13'h0100);
        accepts = 0;
        run(6);
        check("jmp100_after", 32'(accepts), 32'(3 * DEPTH));

        do_jump("jmp1fff", 13'h1FFF);
        accepts = 0;
        run(4);
        check("wrap_count", 32'(accepts), 32'(2 * DEPTH));
        check("wrap_exp", 32'(exp_pc), 32'(2 * DEPTH));

        instr_ready = 1'b0;
        run(4);
        @(negedge clk);
        check("full_valid", 32'(instr_valid), 32'd1);
        check("full_ce", 32'(rom_ce), 32'd0);
        check("full_pc", 32'(instr_pc), 32'(exp_pc));
        next_cycle();

        reset      = 1'b1;
        jump_valid = 1'b1;
        jump_addr  = 13'h0555;
        @(negedge clk);
        check("rst2_ce_now", 32'(rom_ce), 32'd0);
        next_cycle();
        @(negedge clk);
        check("rst2_valid", 32'(instr_valid), 32'd0);
        check("rst2_instr", 32'(instr), 32'd0);
        check("rst2_pc", 32'(instr_pc), 32'd0);
        check("rst2_ce", 32'(rom_ce), 32'd0);
        check("rst2_ad", 32'(rom_ad), 32'd0);
        next_cycle();

        reset       = 1'b0;
        jump_valid  = 1'b0;
        instr_ready = 1'b1;
        exp_pc      = '0;
        startup_checks("reboot");
        accepts = 0;
        run(8);
        check("reboot_count", 32'(accepts), 32'(4 * DEPTH));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the brus16 core: the read-side master of the 16-bit × 8192-word Gowin program pROM. It generates ROM addresses, absorbs the ROM's one-cycle synchronous read latency, tags each returned word with its address, and hands instructions to decode over a valid/ready handshake. Branch redirects from execute flush in-flight and buffered words.

## Interface
Parameters:
- ADDR_WIDTH, 13, ROM word-address width; PC width
- DATA_WIDTH, 16, instruction width
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  system clock; ROM shares it
- reset  in  1  synchronous, active-high reset
- rom_ad  out  ADDR_WIDTH  ROM address; sampled by ROM on clk edge
- rom_ce  out  1  ROM clock enable; high only on issuing cycles
- rom_oce  out  1  constant 1 (ROM in bypass read mode)
- rom_reset  out  1  equals reset
- rom_dout  in  DATA_WIDTH  ROM data, valid the cycle after an issue
- instr_valid  out  1  instr/instr_pc hold a fetched word
- instr_ready  in  1  decode accepts this cycle
- instr  out  DATA_WIDTH  instruction word
- instr_pc  out  ADDR_WIDTH  address of instr
- jump_valid  in  1  redirect request, single-cycle
- jump_addr  in  ADDR_WIDTH  redirect target

## Operation
- State: pc (next issue address), inflight flag, output buffer of DEPTH entries {instr, instr_pc} (DEPTH = 2 or 1, see Configuration), count.
- pop = instr_valid & instr_ready. push = inflight & !jump_valid.
- Issue when reset low and (count + inflight − pop) < DEPTH, or when jump_valid (always issues). On issue: rom_ce=1, rom_ad = jump_valid ? jump_addr : pc; pc ← issued address + 1 (mod 2^ADDR_WIDTH, 0x1FFF → 0x0000); inflight ← 1. No issue: rom_ce=0, rom_ad=pc, inflight ← 0.
- Return: when inflight, rom_dout tagged with latched issue address is written to buffer tail (push).
- Jump: buffer cleared, the in-flight return discarded, target issued same cycle. A pop coinciding with jump completes (word consumed), then buffer is empty.
- Buffer is FIFO; instr/instr_pc driven from head registers, stable while instr_valid & !instr_ready.
- Overflow impossible by issue rule; push and pop in one cycle keep count.

## Timing
- Reset (any cycle, including mid-run/buffer full): next cycle instr_valid=0, instr=0, instr_pc=0, rom_ce=0, rom_ad=RESET_PC, count=0, inflight=0, pc=RESET_PC; jump_valid ignored.
- First low-reset cycle C0: issue RESET_PC; rom_dout valid C1; instr_valid=1 in C2, instr_pc=RESET_PC.
- Fetch latency: issue → instr_valid 2 cycles. Jump at cycle J → instr_pc=jump_addr valid at J+2; instr_valid=0 at J+1.
- Throughput with ready held high: 1 instr/cycle (DEPTH 2), 1 per 2 cycles (DEPTH 1).
- After ready drops, at most DEPTH words buffered; rom_ce low once full; resume loses/duplicates no PC.

## Configuration
- FETCH_SKID_EN defined: DEPTH=2 two-entry skid buffer, full throughput.
- Undefined: DEPTH=1 single output register, issue only when register empty or popping with nothing in flight; half throughput, fewer registers. Interface and latency identical.

## Test plan
- Reset release, ready=1, ROM model dout = ad ^ 16'hA5A5 -> instr_valid rises C2; instr_pc 0,1,2,… every cycle; instr = pc ^ 16'hA5A5.
- ready low 5 cycles mid-stream -> instr/instr_pc frozen, rom_ce low once 2 words buffered, no loss/duplication on resume.
- jump_valid, jump_addr=0x0100 while word in flight and buffer holds 1 -> instr_valid=0 at J+1, instr_pc=0x0100 at J+2, then 0x0101; discarded words never appear.
- jump to 0x1FFF, ready=1 -> instr_pc 0x1FFF then 0x0000.
- reset asserted with buffer full -> next cycle instr_valid=0, rom_ce=0; after release restarts at RESET_PC with C2 latency.
- FETCH_SKID_EN undefined, ready=1 steady -> instr_valid high every other cycle, instr_pc increments by 1 per accepted word.
